// File: rtl/pwm_sample_dac.sv
// pwm_sample_dac
//
// Audio DAC stage for the PWM clock domain. PCM sample codes arrive on a
// valid/ready stream and are buffered in a small circular FIFO. The current
// duty code sets a 1-bit PWM waveform with a period of 2^CODE_WIDTH clocks.
// Each sample is held for SAMPLE_PERIODS PWM periods. At every sample
// boundary the next queued code becomes the duty code. If the FIFO is empty
// at a boundary, the previous code is held and a sticky underflow flag is set.
//
// Ports
//   clk             PWM-domain clock
//   rst             synchronous active-high reset
//   enable          runs the PWM/sample counters; when low the counters
//                   sit at 0 and pwm_out is low
//   in_code         sample code to enqueue
//   in_valid        in_code is valid
//   in_ready        FIFO can accept a code (fifo_count < FIFO_DEPTH)
//   underflow_clear clears the sticky underflow flag
//   pwm_out         registered PWM bit (drives the AUD_PWM IOB register)
//   sample_tick     one-cycle pulse following each sample boundary
//   fifo_count      number of codes currently queued
//   underflow       sticky: a sample boundary found the FIFO empty

module pwm_sample_dac #(
    parameter int CODE_WIDTH     = 10,
    parameter int SAMPLE_PERIODS = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int RESET_CODE     = 2 ** (CODE_WIDTH - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CODE_WIDTH-1:0]         in_code,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          underflow_clear,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PER_W = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;

    localparam logic [CODE_WIDTH-1:0] PWM_LAST = {CODE_WIDTH{1'b1}};
    localparam logic [PER_W-1:0]      PER_LAST = PER_W'(SAMPLE_PERIODS - 1);
    localparam logic [PTR_W:0]        DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [CODE_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PER_W-1:0]      per_cnt_q, per_cnt_d;
    logic [CODE_WIDTH-1:0] duty_q, duty_d;
    logic                  pwm_q, pwm_d;
    logic                  tick_q, tick_d;
    logic                  underflow_q, underflow_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CODE_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic boundary;
    logic fifo_empty;

    // in_ready depends only on registered count, so there is no
    // combinational path from in_valid to in_ready.
    assign in_ready   = (count_q < DEPTH_C);
    assign fifo_empty = (count_q == '0);

    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign fifo_count  = count_q;
    assign underflow   = underflow_q;

    // Next-state logic for counters, duty, FIFO bookkeeping and flags.
    // The pop reads the FIFO before this cycle's push lands, so a push into an
    // empty FIFO on the boundary cycle is not seen and counts as underflow.
    always_comb begin
        push     = in_valid && in_ready;
        boundary = enable && (pwm_cnt_q == PWM_LAST) && (per_cnt_q == PER_LAST);
        pop      = boundary && !fifo_empty;

        pwm_cnt_d = '0;
        per_cnt_d = '0;
        if (enable) begin
            pwm_cnt_d = pwm_cnt_q + CODE_WIDTH'(1);
            per_cnt_d = per_cnt_q;
            if (pwm_cnt_q == PWM_LAST) begin
                per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
            end
        end

        // Compare uses the old duty; a newly popped duty first governs the
        // period that starts at pwm_cnt = 0 on the following cycle.
        pwm_d  = enable && (pwm_cnt_q < duty_q);
        tick_d = boundary;
        duty_d = pop ? mem_q[rd_ptr_q] : duty_q;

        // A set on an empty boundary takes priority over a same-cycle clear.
        underflow_d = underflow_q;
        if (boundary && fifo_empty) begin
            underflow_d = 1'b1;
        end else if (underflow_clear) begin
            underflow_d = 1'b0;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    // State registers with synchronous reset. Reset drops all queued samples
    // and returns the duty to the silence code.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            per_cnt_q   <= '0;
            duty_q      <= CODE_WIDTH'(RESET_CODE);
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
            underflow_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            per_cnt_q   <= per_cnt_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            tick_q      <= tick_d;
            underflow_q <= underflow_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

endmodule
